// File: rtl/pattern_sweep_pkg.sv
// Shared types and constants for the exhaustive pattern sweep stage.
package pattern_sweep_pkg;

  localparam int unsigned SETTLE_W      = 8;
  localparam int unsigned DEF_N_WIDTH   = 5;
  localparam int unsigned DEF_OUT_WIDTH = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // One logged record at the default bus widths.
  typedef struct packed {
    logic [DEF_N_WIDTH-1:0]   pattern;
    logic [DEF_OUT_WIDTH-1:0] resp;
  } rec_t;

endpackage

// File: rtl/sweep_settle_counter.sv
// Settle-time counter: counts cycles a pattern has been held, flags the sample cycle.
module sweep_settle_counter
  import pattern_sweep_pkg::*;
#(
  parameter int unsigned TERM = 1
) (
  input  logic CK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  logic [SETTLE_W-1:0] count;

  // Count held cycles; clear has priority over enable.
  always_ff @(posedge CK) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + SETTLE_W'(1);
    end
  end

  // Terminal count marks the edge on which the response is sampled.
  assign tc_c = (count == SETTLE_W'(TERM - 1));

endmodule

// File: rtl/pattern_sweep_capture.sv
// Drives every input pattern in ascending order, samples the response after a
// settle time and hands (pattern, response) records downstream via valid/ready.
module pattern_sweep_capture
  import pattern_sweep_pkg::*;
#(
  parameter int unsigned N_WIDTH       = 5,
  parameter int unsigned OUT_WIDTH     = 1,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_WIDTH-1:0]   pat_out,
  input  logic [OUT_WIDTH-1:0] dut_resp,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_pattern,
  output logic [OUT_WIDTH-1:0] rec_resp,
  output logic                 busy,
  output logic                 done,
  output logic [N_WIDTH:0]     ones_count
);

  state_t               state, state_d;
  logic [N_WIDTH-1:0]   pat_d, rec_pattern_d;
  logic [OUT_WIDTH-1:0] rec_resp_d;
  logic                 rec_valid_d, busy_d, done_d;
  logic [N_WIDTH:0]     ones_d;
  logic                 cnt_clr, cnt_en, cnt_tc;

  sweep_settle_counter #(
    .TERM (SETTLE_CYCLES)
  ) u_settle (
    .CK     (CK),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .tc_c   (cnt_tc)
  );

  // State and registered outputs.
  always_ff @(posedge CK) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pat_out     <= '0;
      rec_pattern <= '0;
      rec_resp    <= '0;
      rec_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ones_count  <= '0;
    end else begin
      state       <= state_d;
      pat_out     <= pat_d;
      rec_pattern <= rec_pattern_d;
      rec_resp    <= rec_resp_d;
      rec_valid   <= rec_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      ones_count  <= ones_d;
    end
  end

  // Next-state and next-output decisions; everything holds unless changed.
  always_comb begin
    state_d       = state;
    pat_d         = pat_out;
    rec_pattern_d = rec_pattern;
    rec_resp_d    = rec_resp;
    rec_valid_d   = rec_valid;
    busy_d        = busy;
    done_d        = done;
    ones_d        = ones_count;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          pat_d   = '0;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ones_d  = '0;
        end
      end

      ST_APPLY: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          rec_pattern_d = pat_out;
          rec_resp_d    = dut_resp;
          rec_valid_d   = 1'b1;
          state_d       = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (rec_valid && rec_ready) begin
          rec_valid_d = 1'b0;
          if (rec_resp != '0) begin
            ones_d = ones_count + (N_WIDTH + 1)'(1);
          end
          // The last pattern ends the sweep instead of wrapping to zero.
          if (pat_out == '1) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pat_d   = pat_out + N_WIDTH'(1);
            cnt_clr = 1'b1;
            state_d = ST_APPLY;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Directed bench for pattern_sweep_capture: default instance plus a SETTLE_CYCLES=3 instance.
module tb_pattern_sweep_capture;
  import pattern_sweep_pkg::*;

  logic CK = 1'b0;
  logic reset = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int failures = 0;

  // Default-parameter instance.
  logic       start1 = 1'b0;
  logic       ready1 = 1'b1;
  logic [4:0] pat1, rec_pat1;
  logic       resp1, rec_resp1, valid1, busy1, done1;
  logic [5:0] ones1;
  int         mode = 0;

  // Response model for the default instance, selected by mode.
  always_comb begin
    case (mode)
      0:       resp1 = pat1[0];
      1:       resp1 = 1'b1;
      default: resp1 = (pat1 == 5'd31);
    endcase
  end

  pattern_sweep_capture u_dut (
    .CK          (CK),
    .reset       (reset),
    .start       (start1),
    .pat_out     (pat1),
    .dut_resp    (resp1),
    .rec_valid   (valid1),
    .rec_ready   (ready1),
    .rec_pattern (rec_pat1),
    .rec_resp    (rec_resp1),
    .busy        (busy1),
    .done        (done1),
    .ones_count  (ones1)
  );

  // SETTLE_CYCLES=3 instance driving a DUT model with a 2-cycle output delay.
  logic       start3 = 1'b0;
  logic       ready3 = 1'b1;
  logic [4:0] pat3, rec_pat3;
  logic       resp3, rec_resp3, valid3, busy3, done3;
  logic [5:0] ones3;
  logic       d1 = 1'b0, d2 = 1'b0;

  always @(posedge CK) begin
    d1 <= ^pat3;
    d2 <= d1;
  end
  assign resp3 = d2;

  pattern_sweep_capture #(
    .N_WIDTH       (5),
    .OUT_WIDTH     (1),
    .SETTLE_CYCLES (3)
  ) u_dut3 (
    .CK          (CK),
    .reset       (reset),
    .start       (start3),
    .pat_out     (pat3),
    .dut_resp    (resp3),
    .rec_valid   (valid3),
    .rec_ready   (ready3),
    .rec_pattern (rec_pat3),
    .rec_resp    (rec_resp3),
    .busy        (busy3),
    .done        (done3),
    .ones_count  (ones3)
  );

  // Number of transfers of pattern 3 on the default instance.
  int xfer3 = 0;
  always @(posedge CK) begin
    if (reset && valid1 && ready1 && rec_pat1 == 5'd3) xfer3 <= xfer3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_resp(input int m, input int i);
    case (m)
      0:       return i[0];
      1:       return 1'b1;
      default: return (i == 31);
    endcase
  endfunction

  // Full sweep on the default instance with rec_ready high; caller is at a negedge.
  task automatic sweep1(input string tag, input int exp_ones);
    int   cyc;
    int   nrec;
    rec_t got_rec, exp_rec;
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    check({tag, "_start_pat"},  32'(pat1),  32'd0);
    check({tag, "_start_busy"}, 32'(busy1), 32'd1);
    check({tag, "_start_done"}, 32'(done1), 32'd0);
    check({tag, "_start_ones"}, 32'(ones1), 32'd0);
    cyc  = 0;
    nrec = 0;
    while (!done1 && cyc < 400) begin
      if (valid1 && ready1) begin
        got_rec = '{pattern: rec_pat1, resp: rec_resp1};
        exp_rec = '{pattern: 5'(nrec), resp: exp_resp(mode, nrec)};
        check({tag, "_rec"}, 32'(got_rec), 32'(exp_rec));
        nrec++;
      end
      @(negedge CK);
      cyc++;
    end
    check({tag, "_cycles"}, 32'(cyc),   32'd64);
    check({tag, "_nrec"},   32'(nrec),  32'd32);
    check({tag, "_ones"},   32'(ones1), 32'(exp_ones));
    check({tag, "_busy"},   32'(busy1), 32'd0);
    check({tag, "_pat"},    32'(pat1),  32'd31);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int cyc;
    int nrec;
    logic [4:0] p;

    // Reset state
    repeat (3) @(negedge CK);
    check("rst_pat",   32'(pat1),   32'd0);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_done",  32'(done1),  32'd0);
    check("rst_ones",  32'(ones1),  32'd0);
    reset = 1'b1;
    @(negedge CK);

    // Alternating response, then all-ones, then only pattern 31
    mode = 0; sweep1("walk", 16);
    mode = 1; sweep1("allones", 32);
    mode = 2; sweep1("last", 1);
    mode = 0;

    // Back-pressure at pattern 3
    base = xfer3;
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    n = 0;
    while (!(pat1 == 5'd3 && !valid1) && n < 100) begin @(negedge CK); n++; end
    check("bp_reach", 32'(pat1), 32'd3);
    ready1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CK);
      check("bp_valid",   32'(valid1),   32'd1);
      check("bp_rec_pat", 32'(rec_pat1), 32'd3);
      check("bp_pat",     32'(pat1),     32'd3);
    end
    ready1 = 1'b1;
    @(negedge CK);
    check("bp_after_valid", 32'(valid1), 32'd0);
    check("bp_after_pat",   32'(pat1),   32'd4);
    @(negedge CK);
    check("bp_next_valid", 32'(valid1),   32'd1);
    check("bp_next_pat",   32'(rec_pat1), 32'd4);
    n = 0;
    while (!done1 && n < 200) begin @(negedge CK); n++; end
    check("bp_done",  32'(done1),        32'd1);
    check("bp_once",  32'(xfer3 - base), 32'd1);
    check("bp_ones",  32'(ones1),        32'd16);

    // Start pulses during APPLY and CAPTURE are ignored
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    n = 0;
    while (!(pat1 == 5'd2 && !valid1) && n < 100) begin @(negedge CK); n++; end
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    check("ign_apply_valid", 32'(valid1),   32'd1);
    check("ign_apply_rec",   32'(rec_pat1), 32'd2);
    check("ign_apply_pat",   32'(pat1),     32'd2);
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    check("ign_cap_pat",   32'(pat1),   32'd3);
    check("ign_cap_busy",  32'(busy1),  32'd1);
    check("ign_cap_valid", 32'(valid1), 32'd0);
    n = 0;
    while (!done1 && n < 200) begin @(negedge CK); n++; end
    check("ign_done", 32'(done1), 32'd1);
    check("ign_ones", 32'(ones1), 32'd16);
    check("ign_pat",  32'(pat1),  32'd31);

    // Start in DONE restarts cleanly
    start1 = 1'b1;
    @(negedge CK);
    start1 = 1'b0;
    check("rs_done", 32'(done1), 32'd0);
    check("rs_ones", 32'(ones1), 32'd0);
    check("rs_pat",  32'(pat1),  32'd0);
    check("rs_busy", 32'(busy1), 32'd1);

    // Reset mid-sweep at pattern 5
    n = 0;
    while (pat1 != 5'd5 && n < 100) begin @(negedge CK); n++; end
    check("mid_reach", 32'(pat1), 32'd5);
    @(negedge CK);
    reset = 1'b0;
    @(negedge CK);
    reset = 1'b1;
    check("mid_pat",   32'(pat1),   32'd0);
    check("mid_valid", 32'(valid1), 32'd0);
    check("mid_busy",  32'(busy1),  32'd0);
    check("mid_done",  32'(done1),  32'd0);
    check("mid_ones",  32'(ones1),  32'd0);
    @(negedge CK);
    check("mid_idle_busy", 32'(busy1), 32'd0);
    check("mid_idle_pat",  32'(pat1),  32'd0);
    sweep1("restart", 16);

    // Settle of 3 cycles against a 2-cycle-latency DUT
    start3 = 1'b1;
    @(negedge CK);
    start3 = 1'b0;
    check("s3_start_pat", 32'(pat3), 32'd0);
    cyc  = 0;
    nrec = 0;
    while (!done3 && cyc < 600) begin
      if (valid3 && ready3) begin
        p = 5'(nrec);
        check("s3_rec_pat",  32'(rec_pat3),  32'(p));
        check("s3_rec_resp", 32'(rec_resp3), 32'(^p));
        nrec++;
      end
      @(negedge CK);
      cyc++;
    end
    check("s3_cycles", 32'(cyc),   32'd128);
    check("s3_nrec",   32'(nrec),  32'd32);
    check("s3_ones",   32'(ones3), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_sweep_capture.md
Name: pattern_sweep_capture

Overview:
Synthesizable upstream stimulus stage for the exhaustive-sweep trojan-detection flow. It drives every input pattern 0..2^N_WIDTH-1 in ascending order onto the DUT input bus. For each pattern it waits a programmable settle time, samples the DUT response, and emits a (pattern, response) record over a valid/ready interface to the downstream logger. It also keeps a running count of patterns whose response is non-zero.

Parameters:
N_WIDTH, 5, width of the DUT input bus; the sweep covers 2^N_WIDTH patterns.
OUT_WIDTH, 1, width of the DUT response bus.
SETTLE_CYCLES, 1, cycles each pattern is held before sampling; legal range 1..255.

Ports:
CK  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  one-cycle pulse; begins a sweep when the block is idle or done.
pat_out  output  N_WIDTH  pattern driven to the DUT inputs; bit N_WIDTH-1 is the MSB.
dut_resp  input  OUT_WIDTH  DUT response to pat_out.
rec_valid  output  1  a record is available.
rec_ready  input  1  the downstream stage accepts the record.
rec_pattern  output  N_WIDTH  pattern of the current record.
rec_resp  output  OUT_WIDTH  sampled response of the current record.
busy  output  1  high from start acceptance until the final record transfers.
done  output  1  high after a completed sweep, until the next accepted start.
ones_count  output  N_WIDTH+1  number of transferred records with rec_resp != 0.

Behaviour:
- Reset (reset==0 at a CK edge) has priority over everything and applies regardless of state:
  - state goes to IDLE;
  - pat_out, rec_pattern, rec_resp and ones_count go to 0;
  - rec_valid, busy and done go to 0.
  - Reset mid-sweep abandons the sweep and drops any pending record.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE or DONE with start==1:
  - next cycle: state=APPLY, pat_out=0, settle counter=0, busy=1, done=0, ones_count=0.
  - start in APPLY or CAPTURE is ignored.
- APPLY:
  - pat_out is held; the settle counter increments each cycle.
  - On the cycle where counter==SETTLE_CYCLES-1, dut_resp is sampled at that edge: rec_pattern<=pat_out, rec_resp<=dut_resp, rec_valid<=1, state<=CAPTURE.
- CAPTURE:
  - rec_valid, rec_pattern and rec_resp stay stable until rec_valid&&rec_ready.
  - pat_out is held, so the DUT input is unchanged while back-pressured.
  - On transfer:
    - rec_valid<=0;
    - ones_count increments if rec_resp!=0;
    - if pat_out==all-ones: state<=DONE, busy<=0, done<=1, pat_out holds all-ones;
    - otherwise: pat_out<=pat_out+1, counter<=0, state<=APPLY.
- If rec_ready is already high when rec_valid rises, the transfer happens in that first CAPTURE cycle.
  - Per-pattern cost is SETTLE_CYCLES+1 cycles minimum.
  - A full sweep with default parameters takes 64 cycles from start acceptance to done.
- Wrap-around: the pattern counter never wraps. Reaching all-ones ends the sweep.
- Arithmetic:
  - pat_out increment is N_WIDTH-bit unsigned.
  - ones_count is N_WIDTH+1 bits, so it cannot overflow (maximum 2^N_WIDTH).
- DONE: outputs hold; ones_count stays readable; a new start restarts from pattern 0.

Decomposition:
- Shared package pattern_sweep_pkg holds:
  - the FSM state enum (IDLE, APPLY, CAPTURE, DONE), 2-bit;
  - the SETTLE counter width constant (8);
  - a record struct {pattern, resp} parameterised by the default widths.
- One sub-module is natural: sweep_settle_counter, the 8-bit settle counter with clear/enable and a terminal-count flag.
- The FSM, record register and ones counter stay in the top module.

Test Plan:
1. Reset mid-sweep: assert reset low at pattern 5 -> next edge pat_out=0, rec_valid=0, busy=0, done=0, ones_count=0; a later start restarts cleanly at pattern 0.
2. rec_ready tied 1, SETTLE_CYCLES=1, dut_resp=pat_out[0] -> 32 records with patterns 0..31 in order, rec_resp alternating 0,1; done rises 64 cycles after start acceptance; ones_count=16.
3. Back-pressure: rec_ready low for 7 cycles at pattern 3 -> rec_valid, rec_pattern=3 and pat_out=3 stay stable; the record transfers exactly once; the next record is pattern 4.
4. SETTLE_CYCLES=3 with a DUT model having 2-cycle output delay -> every rec_resp matches the response to its own pattern; the sweep takes 128 cycles.
5. Start pulses during APPLY and CAPTURE are ignored, with no restart. A start in DONE clears done next cycle, resets ones_count to 0 and drives pat_out=0.
6. dut_resp tied all-ones -> ones_count=32 at done. A response that is non-zero only for pattern 31 -> ones_count=1, and done follows that final transfer.
